// File: rtl/i2c_target_byte_if.sv
// i2c_target_byte_if: byte-level I2C target engine.
// Oversamples SCL/SDA on Clk, detects START/STOP, matches a 7-bit address,
// hands write bytes to the user port and serialises read bytes from it.
// SDA is driven through an open-drain enable (Sda_oe = 1 pulls the line low).
// Optional build macro: I2C_TARGET_GLITCH_FILTER_EN adds a FILTER_LEN-cycle
// stability filter on both lines after the synchronisers.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | not addressed, SDA released, waiting for START
// ADDR     | shifting in address + R/W bit on SCL rising edges
// ADDR_ACK | address matched; drive ACK for one SCL low/high period
// RX       | shifting in a write data byte
// RX_ACK   | drive ACK (or leave released for NACK) after a write byte
// TX       | driving a read data byte, one bit per SCL falling edge
// TX_ACK   | SDA released, sampling the controller's ACK/NACK

module i2c_target_byte_if #(
    parameter logic [6:0]  ADDR       = 7'h2A,
    parameter int unsigned FILTER_LEN = 3
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       Scl_in,
    input  logic       Sda_in,
    output logic       Sda_oe,
    output logic [7:0] Rx_data,
    output logic       Rx_valid,
    input  logic       Rx_ready,
    input  logic [7:0] Tx_data,
    output logic       Tx_req,
    output logic       Start_det,
    output logic       Stop_det,
    output logic       Busy
);

`ifdef I2C_TARGET_GLITCH_FILTER_EN
    localparam bit FILTER_ON = 1'b1;
`else
    localparam bit FILTER_ON = 1'b0;
`endif

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_RX,
        ST_RX_ACK,
        ST_TX,
        ST_TX_ACK
    } state_t;

    logic [1:0] scl_sync, sda_sync;
    logic       scl_raw, sda_raw;
    logic       scl_f, sda_f;
    logic       scl_prev, sda_prev;
    logic       scl_rise, scl_fall;
    logic       start_flag, stop_flag;

    state_t     state, state_n;
    logic [3:0] bit_cnt, bit_cnt_n;
    logic [7:0] shift, shift_n;
    logic [7:0] shift_in;
    logic       ack_on, ack_on_n;
    logic       nack, nack_n;
    logic       rw, rw_n;
    logic       oe_n, busy_n, rx_valid_n, tx_req_n;
    logic [7:0] rx_data_n;

    // Two-flop synchronisers; reset to 1 so the bus looks idle.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
        end else begin
            scl_sync <= {scl_sync[0], Scl_in};
            sda_sync <= {sda_sync[0], Sda_in};
        end
    end

    assign scl_raw = scl_sync[1];
    assign sda_raw = sda_sync[1];

    generate
        if (FILTER_ON && (FILTER_LEN > 0)) begin : g_filter
            localparam int unsigned FCW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
            localparam logic [FCW-1:0] TMR_LOAD = FCW'(FILTER_LEN - 1);

            logic [FCW-1:0] scl_tmr, sda_tmr;
            logic           scl_q, sda_q;

            // Each filtered line follows its input only after FILTER_LEN
            // consecutive differing samples; the down-counter reloads on any
            // sample that matches the current filtered value.
            always_ff @(posedge Clk) begin
                if (Rst) begin
                    scl_q   <= 1'b1;
                    sda_q   <= 1'b1;
                    scl_tmr <= TMR_LOAD;
                    sda_tmr <= TMR_LOAD;
                end else begin
                    if (scl_raw == scl_q) begin
                        scl_tmr <= TMR_LOAD;
                    end else if (scl_tmr == '0) begin
                        scl_q   <= scl_raw;
                        scl_tmr <= TMR_LOAD;
                    end else begin
                        scl_tmr <= scl_tmr - 1'b1;
                    end
                    if (sda_raw == sda_q) begin
                        sda_tmr <= TMR_LOAD;
                    end else if (sda_tmr == '0) begin
                        sda_q   <= sda_raw;
                        sda_tmr <= TMR_LOAD;
                    end else begin
                        sda_tmr <= sda_tmr - 1'b1;
                    end
                end
            end

            assign scl_f = scl_q;
            assign sda_f = sda_q;
        end else begin : g_nofilter
            assign scl_f = scl_raw;
            assign sda_f = sda_raw;
        end
    endgenerate

    // One-cycle history for edge and START/STOP detection.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            scl_prev <= 1'b1;
            sda_prev <= 1'b1;
        end else begin
            scl_prev <= scl_f;
            sda_prev <= sda_f;
        end
    end

    assign scl_rise   = scl_f & ~scl_prev;
    assign scl_fall   = ~scl_f & scl_prev;
    assign start_flag = scl_f & scl_prev & sda_prev & ~sda_f;
    assign stop_flag  = scl_f & scl_prev & ~sda_prev & sda_f;
    assign shift_in   = {shift[6:0], sda_f};

    // State register and all registered outputs.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state     <= ST_IDLE;
            bit_cnt   <= 4'd0;
            shift     <= 8'h00;
            ack_on    <= 1'b0;
            nack      <= 1'b0;
            rw        <= 1'b0;
            Sda_oe    <= 1'b0;
            Rx_data   <= 8'h00;
            Rx_valid  <= 1'b0;
            Tx_req    <= 1'b0;
            Start_det <= 1'b0;
            Stop_det  <= 1'b0;
            Busy      <= 1'b0;
        end else begin
            state     <= state_n;
            bit_cnt   <= bit_cnt_n;
            shift     <= shift_n;
            ack_on    <= ack_on_n;
            nack      <= nack_n;
            rw        <= rw_n;
            Sda_oe    <= oe_n;
            Rx_data   <= rx_data_n;
            Rx_valid  <= rx_valid_n;
            Tx_req    <= tx_req_n;
            Start_det <= start_flag;
            Stop_det  <= stop_flag;
            Busy      <= busy_n;
        end
    end

    // Next-state and datapath; START/STOP take priority over SCL edges.
    always_comb begin
        state_n    = state;
        bit_cnt_n  = bit_cnt;
        shift_n    = shift;
        ack_on_n   = ack_on;
        nack_n     = nack;
        rw_n       = rw;
        oe_n       = Sda_oe;
        rx_data_n  = Rx_data;
        rx_valid_n = 1'b0;
        tx_req_n   = 1'b0;
        busy_n     = Busy;

        if (stop_flag) begin
            state_n   = ST_IDLE;
            bit_cnt_n = 4'd0;
            ack_on_n  = 1'b0;
            oe_n      = 1'b0;
            busy_n    = 1'b0;
        end else if (start_flag) begin
            state_n   = ST_ADDR;
            bit_cnt_n = 4'd0;
            ack_on_n  = 1'b0;
            oe_n      = 1'b0;
            busy_n    = 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                end
                ST_ADDR: begin
                    if (scl_rise) begin
                        shift_n = shift_in;
                        if (bit_cnt == 4'd7) begin
                            bit_cnt_n = 4'd0;
                            if (shift_in[7:1] == ADDR) begin
                                state_n  = ST_ADDR_ACK;
                                busy_n   = 1'b1;
                                rw_n     = shift_in[0];
                                ack_on_n = 1'b0;
                            end else begin
                                state_n = ST_IDLE;
                            end
                        end else begin
                            bit_cnt_n = bit_cnt + 4'd1;
                        end
                    end
                end
                ST_ADDR_ACK: begin
                    if (scl_fall) begin
                        if (!ack_on) begin
                            ack_on_n = 1'b1;
                            oe_n     = 1'b1;
                            tx_req_n = rw;
                        end else begin
                            ack_on_n  = 1'b0;
                            bit_cnt_n = 4'd0;
                            if (rw) begin
                                // First read bit goes out on the same fall that ends ACK.
                                shift_n = Tx_data;
                                oe_n    = ~Tx_data[7];
                                state_n = ST_TX;
                            end else begin
                                oe_n    = 1'b0;
                                state_n = ST_RX;
                            end
                        end
                    end
                end
                ST_RX: begin
                    if (scl_rise) begin
                        shift_n = shift_in;
                        if (bit_cnt == 4'd7) begin
                            bit_cnt_n = 4'd0;
                            ack_on_n  = 1'b0;
                            nack_n    = ~Rx_ready;
                            state_n   = ST_RX_ACK;
                            if (Rx_ready) begin
                                rx_data_n  = shift_in;
                                rx_valid_n = 1'b1;
                            end
                        end else begin
                            bit_cnt_n = bit_cnt + 4'd1;
                        end
                    end
                end
                ST_RX_ACK: begin
                    if (scl_fall) begin
                        if (!ack_on) begin
                            ack_on_n = 1'b1;
                            oe_n     = ~nack;
                        end else begin
                            ack_on_n = 1'b0;
                            oe_n     = 1'b0;
                            if (nack) begin
                                state_n = ST_IDLE;
                                busy_n  = 1'b0;
                            end else begin
                                state_n = ST_RX;
                            end
                        end
                    end
                end
                ST_TX: begin
                    if (scl_rise) begin
                        if (bit_cnt != 4'd8) begin
                            bit_cnt_n = bit_cnt + 4'd1;
                            shift_n   = {shift[6:0], 1'b0};
                        end
                    end else if (scl_fall) begin
                        if (bit_cnt == 4'd8) begin
                            bit_cnt_n = 4'd0;
                            ack_on_n  = 1'b0;
                            oe_n      = 1'b0;
                            state_n   = ST_TX_ACK;
                        end else begin
                            oe_n = ~shift[7];
                        end
                    end
                end
                ST_TX_ACK: begin
                    if (scl_rise && !ack_on) begin
                        if (!sda_f) begin
                            tx_req_n = 1'b1;
                            ack_on_n = 1'b1;
                        end else begin
                            state_n = ST_IDLE;
                            busy_n  = 1'b0;
                            oe_n    = 1'b0;
                        end
                    end else if (scl_fall && ack_on) begin
                        ack_on_n  = 1'b0;
                        bit_cnt_n = 4'd0;
                        shift_n   = Tx_data;
                        oe_n      = ~Tx_data[7];
                        state_n   = ST_TX;
                    end
                end
                default: begin
                    state_n = ST_IDLE;
                    oe_n    = 1'b0;
                    busy_n  = 1'b0;
                end
            endcase
        end
    end

endmodule
